// File: rtl/ghash_pkg.sv
// Shared types and helpers for the GHASH multiplier sequencer.
package ghash_pkg;
  localparam int         GHASH_W        = 128;
  // Low-order terms of P = x^128 + x^7 + x^2 + x + 1
  localparam logic [7:0] GHASH_POLY_LOW = 8'h87;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, TAG} ghash_state_e;

  // GCM bit order (bit127 = x^0) <-> polynomial order (bit i = x^i)
  function automatic logic [GHASH_W-1:0] bit_rev128(input logic [GHASH_W-1:0] v);
    logic [GHASH_W-1:0] r;
    for (int i = 0; i < GHASH_W; i++) r[i] = v[GHASH_W-1-i];
    return r;
  endfunction
endpackage

// File: rtl/gf128_reduce.sv
// Combinational fold of a 256-bit carry-less product modulo the GCM polynomial.
module gf128_reduce
  import ghash_pkg::*;
(
  input  logic [2*GHASH_W-1:0] prod,
  output logic [GHASH_W-1:0]   red
);
  logic [2*GHASH_W-1:0] acc;

  // Fold from the top down so terms pushed back above x^127 are folded again.
  always_comb begin
    acc = prod;
    for (int i = 2*GHASH_W-1; i >= GHASH_W; i--)
      if (acc[i]) acc[i-GHASH_W +: 8] = acc[i-GHASH_W +: 8] ^ GHASH_POLY_LOW;
  end

  assign red = acc[GHASH_W-1:0];
endmodule

// File: rtl/ghash_ctrl.sv
// GHASH sequencer around an external single-issue 128x128 carry-less multiplier.
// Optional GHASH_PERF_CNT_EN adds perf_blocks_o (accepted-block counter).
module ghash_ctrl
  import ghash_pkg::*;
#(
  parameter int MUL_TIMEOUT = 64
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 h_valid_i,
  input  logic [GHASH_W-1:0]   h_i,
  input  logic                 blk_valid_i,
  output logic                 blk_ready_o,
  input  logic [GHASH_W-1:0]   blk_i,
  input  logic                 blk_last_i,
  output logic                 tag_valid_o,
  input  logic                 tag_ready_i,
  output logic [GHASH_W-1:0]   tag_o,
  output logic                 mul_valid_o,
  output logic [GHASH_W-1:0]   mul_a_o,
  output logic [GHASH_W-1:0]   mul_b_o,
  input  logic                 mul_valid_i,
  input  logic [2*GHASH_W-1:0] mul_result_i,
`ifdef GHASH_PERF_CNT_EN
  output logic [31:0]          perf_blocks_o,
`endif
  output logic                 err_o
);
  localparam int             CW      = $clog2(MUL_TIMEOUT + 1);
  localparam logic [CW-1:0]  TO_LAST = CW'(MUL_TIMEOUT - 1);

  ghash_state_e       state;
  logic [GHASH_W-1:0] y_q, h_q, red;
  logic               h_loaded, last_q;
  logic [CW-1:0]      to_cnt;

  gf128_reduce u_reduce (.prod(mul_result_i), .red(red));

  // An H load takes priority over a block in the same cycle.
  assign blk_ready_o = (state == IDLE) && h_loaded && !err_o && !h_valid_i;
  assign tag_o       = y_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      y_q         <= '0;
      h_q         <= '0;
      h_loaded    <= 1'b0;
      last_q      <= 1'b0;
      to_cnt      <= '0;
      mul_valid_o <= 1'b0;
      mul_a_o     <= '0;
      mul_b_o     <= '0;
      tag_valid_o <= 1'b0;
      err_o       <= 1'b0;
`ifdef GHASH_PERF_CNT_EN
      perf_blocks_o <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (h_valid_i) begin
            h_q      <= h_i;
            h_loaded <= 1'b1;
          end else if (blk_valid_i && blk_ready_o) begin
            mul_a_o     <= bit_rev128(y_q ^ blk_i);
            mul_b_o     <= bit_rev128(h_q);
            last_q      <= blk_last_i;
            mul_valid_o <= 1'b1;
            state       <= ISSUE;
`ifdef GHASH_PERF_CNT_EN
            if (perf_blocks_o != '1) perf_blocks_o <= perf_blocks_o + 32'd1;
`endif
          end
        end
        ISSUE: begin
          mul_valid_o <= 1'b0;
          to_cnt      <= '0;
          state       <= WAIT;
        end
        WAIT: begin
          if (mul_valid_i) begin
            y_q <= bit_rev128(red);
            if (last_q) begin
              tag_valid_o <= 1'b1;
              state       <= TAG;
            end else begin
              state <= IDLE;
            end
          end else if (to_cnt == TO_LAST) begin
            // Sticky: blk_ready_o stays low until reset.
            err_o <= 1'b1;
            state <= IDLE;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        TAG: begin
          if (tag_ready_i) begin
            tag_valid_o <= 1'b0;
            y_q         <= '0;
            state       <= IDLE;
`ifdef GHASH_PERF_CNT_EN
            perf_blocks_o <= '0;
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ghash_ctrl.sv
// Scoreboard bench for ghash_ctrl: GCM-order reference multiply, carry-less multiplier model.
module tb_ghash_ctrl;
  localparam int TO = 64;
  localparam logic [127:0] UNITY = {1'b1, 127'b0};

  logic         clk = 1'b0, rst_n = 1'b0;
  logic         h_valid_i = 1'b0, blk_valid_i = 1'b0, blk_last_i = 1'b0, tag_ready_i = 1'b0;
  logic [127:0] h_i = '0, blk_i = '0;
  logic         blk_ready_o, tag_valid_o, mul_valid_o, err_o;
  logic [127:0] tag_o, mul_a_o, mul_b_o;
  logic         mul_valid_i;
  logic [255:0] mul_result_i;
`ifdef GHASH_PERF_CNT_EN
  logic [31:0]  perf_blocks_o;
`endif

  always #5 clk = ~clk;

  ghash_ctrl #(.MUL_TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .h_valid_i(h_valid_i), .h_i(h_i),
    .blk_valid_i(blk_valid_i), .blk_ready_o(blk_ready_o), .blk_i(blk_i), .blk_last_i(blk_last_i),
    .tag_valid_o(tag_valid_o), .tag_ready_i(tag_ready_i), .tag_o(tag_o),
    .mul_valid_o(mul_valid_o), .mul_a_o(mul_a_o), .mul_b_o(mul_b_o),
    .mul_valid_i(mul_valid_i), .mul_result_i(mul_result_i),
`ifdef GHASH_PERF_CNT_EN
    .perf_blocks_o(perf_blocks_o),
`endif
    .err_o(err_o)
  );

  int checks = 0, failures = 0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s: bound expired", name);
  endtask

  // ---- reference arithmetic ----
  function automatic logic [127:0] rev(input logic [127:0] v);
    logic [127:0] r;
    for (int i = 0; i < 128; i++) r[i] = v[127-i];
    return r;
  endfunction

  // GF(2^128) multiply directly in GCM bit order (right-shift algorithm).
  function automatic logic [127:0] gmul(input logic [127:0] x, input logic [127:0] y);
    logic [127:0] z, v;
    z = '0;
    v = y;
    for (int i = 0; i < 128; i++) begin
      if (x[127-i]) z = z ^ v;
      v = v[0] ? ((v >> 1) ^ {8'he1, 120'b0}) : (v >> 1);
    end
    return z;
  endfunction

  function automatic logic [255:0] clmul(input logic [127:0] a, input logic [127:0] b);
    logic [255:0] p;
    p = '0;
    for (int i = 0; i < 128; i++) if (a[i]) p = p ^ ({128'b0, b} << i);
    return p;
  endfunction

  typedef struct { logic [127:0] a; logic [127:0] b; } op_t;

  logic [127:0] y_ref = '0, h_ref = '0;
  logic [127:0] exp_q[$];
  op_t          op_q[$];
  op_t          last_op;
  int           mul_pulses = 0, tot_blks = 0, msg_blks = 0;
  bit           mul_respond = 1'b1, spur = 1'b0, mul_spur = 1'b0;
  int           fixed_lat = 0;

  // ---- external multiplier model ----
  int           lat_cnt;
  bit           pend;
  logic [255:0] pend_res;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend <= 1'b0; mul_valid_i <= 1'b0; mul_result_i <= '0; mul_spur <= 1'b0; lat_cnt <= 0;
    end else begin
      mul_valid_i  <= 1'b0;
      mul_spur     <= 1'b0;
      mul_result_i <= {1'b0, 31'($urandom), {7{$urandom}}};
      if (mul_valid_o && mul_respond) begin
        pend     <= 1'b1;
        lat_cnt  <= (fixed_lat != 0) ? fixed_lat : int'($urandom_range(1, 6));
        pend_res <= clmul(mul_a_o, mul_b_o);
      end else if (pend) begin
        if (lat_cnt <= 1) begin
          mul_valid_i <= 1'b1; mul_result_i <= pend_res; pend <= 1'b0;
        end else lat_cnt <= lat_cnt - 1;
      end else if (spur) begin
        mul_valid_i <= 1'b1; mul_spur <= 1'b1;
      end
    end
  end

  // ---- monitor / scoreboard ----
  bit prev_mul = 1'b0;
  always @(negedge clk) begin
    #2;
    if (rst_n) begin
      if (mul_valid_o) begin
        mul_pulses++;
        chk("mul_pulse_width", 256'(prev_mul), 256'(0));
        if (op_q.size() == 0) fail_now("mul_unexpected_issue");
        else begin
          last_op = op_q.pop_front();
          chk("mul_a", 256'(rev(mul_a_o)), 256'(last_op.a));
          chk("mul_b", 256'(rev(mul_b_o)), 256'(last_op.b));
        end
      end
      if (mul_valid_i && !mul_spur)
        chk("mul_ops_held", {rev(mul_a_o), rev(mul_b_o)}, {last_op.a, last_op.b});
      if (tag_valid_o && tag_ready_i) begin
        if (exp_q.size() == 0) fail_now("tag_unexpected");
        else chk("tag", 256'(tag_o), 256'(exp_q.pop_front()));
      end
    end
    prev_mul = mul_valid_o && rst_n;
  end

  // ---- stimulus helpers (called at negedge) ----
  task automatic load_h(input logic [127:0] h);
    h_valid_i = 1'b1; h_i = h;
    @(negedge clk);
    h_valid_i = 1'b0;
    h_ref = h;
  endtask

  task automatic send_blk(input logic [127:0] x, input bit last, input bit use_exp, input logic [127:0] e);
    bit hs = 1'b0;
    blk_valid_i = 1'b1; blk_i = x; blk_last_i = last;
    for (int n = 0; n < 400 && !hs; n++) begin
      #1;
      hs = blk_ready_o;
      if (hs) begin
        op_q.push_back('{a: y_ref ^ x, b: h_ref});
        y_ref = gmul(y_ref ^ x, h_ref);
        msg_blks++; tot_blks++;
        if (last) begin
          exp_q.push_back(use_exp ? e : y_ref);
          y_ref = '0;
        end
      end
      @(negedge clk);
    end
    blk_valid_i = 1'b0; blk_last_i = 1'b0;
    if (!hs) fail_now("blk_accept");
  endtask

  task automatic wait_tag(input int hold);
    bit got = 1'b0;
    for (int n = 0; n < 400 && !got; n++) begin
      #1;
      got = tag_valid_o;
      if (!got) @(negedge clk);
    end
    if (!got) begin fail_now("tag_wait"); return; end
    spur = 1'b1;
    for (int i = 0; i < hold; i++) begin
      chk("tag_hold", {126'b0, tag_valid_o, blk_ready_o, tag_o},
          {126'b0, 1'b1, 1'b0, (exp_q.size() != 0) ? exp_q[0] : 128'hx});
      @(negedge clk); #1;
    end
    spur = 1'b0;
`ifdef GHASH_PERF_CNT_EN
    chk("perf_blocks", 256'(perf_blocks_o), 256'(msg_blks));
`endif
    tag_ready_i = 1'b1;
    @(negedge clk);
    tag_ready_i = 1'b0;
    msg_blks = 0;
  endtask

  task automatic clear_model();
    exp_q.delete(); op_q.delete();
    y_ref = '0; h_ref = '0; msg_blks = 0;
  endtask

  // ---- main sequence ----
  initial begin
    logic [127:0] x0, xr, hr;
    int p0, nb, n;
    bit ok;
    x0 = 128'h0123456789abcdef0011223344556677;

    repeat (3) @(negedge clk);
    #1;
    chk("reset_ctl", {124'b0, tag_valid_o, mul_valid_o, err_o, blk_ready_o, tag_o}, 256'(0));
    chk("reset_ops", {mul_a_o, mul_b_o}, 256'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Block before any H is stalled; H and block together -> H first.
    blk_valid_i = 1'b1; blk_i = x0; blk_last_i = 1'b1;
    ok = 1'b1;
    for (int i = 0; i < 5; i++) begin #1; if (blk_ready_o) ok = 1'b0; @(negedge clk); end
    chk("no_h_stall", 256'(ok), 256'(1));
    h_valid_i = 1'b1; h_i = UNITY;
    #1 chk("h_blk_coincide_ready", 256'(blk_ready_o), 256'(0));
    @(negedge clk);
    h_valid_i = 1'b0; h_ref = UNITY;
    #1 chk("ready_after_h", 256'(blk_ready_o), 256'(1));
    p0 = mul_pulses;
    send_blk(x0, 1'b1, 1'b1, x0);
    wait_tag(0);
    chk("one_mul_pulse", 256'(mul_pulses - p0), 256'(1));

    // H = x, X = x^127 -> x^128 reduced.
    load_h({2'b01, 126'b0});
    send_blk(128'h1, 1'b1, 1'b1, 128'he1000000000000000000000000000000);
    wait_tag(2);

    // Two-block message with back-pressured tag, then a fresh message from Y = 0.
    load_h(UNITY);
    send_blk({16'hffff, 112'b0}, 1'b0, 1'b0, '0);
    send_blk({16{8'h0f}}, 1'b1, 1'b1, 128'hf0f00f0f0f0f0f0f0f0f0f0f0f0f0f0f);
    wait_tag(10);
    xr = {$urandom, $urandom, $urandom, $urandom};
    send_blk(xr, 1'b1, 1'b1, xr);
    wait_tag(1);

    // Randomized messages against the reference model.
    for (int m = 0; m < 8; m++) begin
      load_h({$urandom, $urandom, $urandom, $urandom});
      nb = int'($urandom_range(1, 4));
      for (int b = 0; b < nb; b++)
        send_blk({$urandom, $urandom, $urandom, $urandom}, b == nb - 1, 1'b0, '0);
      wait_tag(int'($urandom_range(0, 3)));
    end

    // Reset while waiting on the multiplier.
    load_h({$urandom, $urandom, $urandom, $urandom});
    fixed_lat = 30;
    send_blk({$urandom, $urandom, $urandom, $urandom}, 1'b1, 1'b0, '0);
    repeat (5) @(negedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("midwait_reset_ctl", {124'b0, tag_valid_o, mul_valid_o, err_o, blk_ready_o, tag_o}, 256'(0));
    chk("midwait_reset_ops", {mul_a_o, mul_b_o}, 256'(0));
    clear_model();
    @(negedge clk);
    rst_n = 1'b1;
    fixed_lat = 0;
    @(negedge clk);
    hr = {$urandom, $urandom, $urandom, $urandom};
    load_h(hr);
    send_blk({$urandom, $urandom, $urandom, $urandom}, 1'b1, 1'b0, '0);
    wait_tag(0);

    // Multiplier never answers -> sticky timeout.
    mul_respond = 1'b0;
    send_blk({$urandom, $urandom, $urandom, $urandom}, 1'b0, 1'b0, '0);
    #1;
    for (n = 0; n < TO + 20; n++) begin
      if (err_o) break;
      @(negedge clk); #1;
    end
    if (!err_o) fail_now("err_wait");
    else chk("err_timing", 256'(n >= TO && n <= TO + 2), 256'(1));
    @(negedge clk);
    blk_valid_i = 1'b1; blk_i = '1;
    ok = 1'b1;
    for (int i = 0; i < 8; i++) begin #1; if (blk_ready_o || !err_o) ok = 1'b0; @(negedge clk); end
    blk_valid_i = 1'b0;
    chk("err_sticky_no_ready", 256'(ok), 256'(1));
    rst_n = 1'b0;
    #1 chk("err_cleared_by_reset", 256'(err_o), 256'(0));
    clear_model();
    @(negedge clk);
    rst_n = 1'b1;
    mul_respond = 1'b1;
    @(negedge clk);
    load_h({$urandom, $urandom, $urandom, $urandom});
    send_blk({$urandom, $urandom, $urandom, $urandom}, 1'b0, 1'b0, '0);
    send_blk({$urandom, $urandom, $urandom, $urandom}, 1'b1, 1'b0, '0);
    wait_tag(1);

    repeat (3) @(negedge clk);
    chk("pulses_vs_blocks", 256'(mul_pulses), 256'(tot_blks));
    chk("scoreboard_drained", 256'(exp_q.size()), 256'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
